seq_bit_tx: RTL and testbench
=============================

Name: seq_bit_tx

Overview:
- Serial stimulus transmitter: accepts a parallel WIDTH-bit pattern over a valid/ready handshake and drives it MSB-first, one bit per enabled cycle, onto a single-bit serial line.
- The serial line is the `x` input of the team's serial sequence-detector FSMs.
- Sits between bench/CPU-side pattern source and detector; optional even-parity trailer bit; programmable inter-word gap.

Parameters:
- WIDTH, 8, pattern length in bits (>=2).
- GAP_CYCLES, 1, idle enabled-cycles inserted after each word before next accept (0 allowed).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- load_valid  input  1  source offers load_data.
- load_data  input  WIDTH  pattern to send, bit WIDTH-1 sent first.
- load_ready  output  1  transmitter can accept a word this cycle.
- bit_en  input  1  bit-rate strobe; serial position advances only on cycles with bit_en=1.
- x  output  1  serial data bit (registered).
- x_valid  output  1  x carries a pattern/parity bit (registered).
- done  output  1  one-cycle pulse: last bit of word (incl. parity) finished.

Behaviour:
- Reset (rst=1, async): state=IDLE, shift reg=0, bit count=0, gap count=0, x=0, x_valid=0, done=0, load_ready=1.
- All outputs registered except load_ready, which is combinational from state: 1 only in IDLE.
- States: IDLE, SEND, PAR (only with feature), GAP.
- IDLE:
  - Accept on edge where load_valid&&load_ready (bit_en ignored).
  - At the accept edge: shreg<=load_data, x<=load_data[WIDTH-1], x_valid<=1, cnt<=0, state<=SEND.
  - First bit is visible the cycle after acceptance (latency 1).
- SEND, on edge with bit_en=1:
  - If cnt<WIDTH-1: shift left, x<=next bit, cnt<=cnt+1.
  - If cnt==WIDTH-1: go to PAR if feature enabled; else x_valid<=0, x<=0, done<=1, then to GAP (GAP_CYCLES>0) or IDLE (GAP_CYCLES==0).
  - bit_en=0: everything holds; x and x_valid stable.
- Each bit is therefore held until the first bit_en=1 edge after it appears (min 1 cycle).
- GAP: x_valid=0, x=0; count bit_en cycles; after GAP_CYCLES enabled cycles go to IDLE.
- done:
  - High exactly one cycle, coincident with x_valid falling.
  - With GAP_CYCLES==0, a new word may be accepted on the edge after done.
  - Back-to-back words never overlap.
- load_valid while not ready: ignored, no capture; source must hold its data.
- bit count width: clog2(WIDTH); no wrap beyond WIDTH-1.
- Reset mid-word: immediate abort, outputs to reset values, no done pulse.

Optional Feature:
- Macro: SEQ_BIT_TX_PARITY_EN.
- Defined:
  - After the last data bit, PAR state drives x=even parity (XOR of all WIDTH captured bits), x_valid=1, for one enabled bit period.
  - done pulses at PAR exit.
  - Word occupies WIDTH+1 bit periods.
- Undefined: PAR state and parity logic absent; word occupies WIDTH bit periods.

Test Plan:
- Reset: assert rst mid-SEND of 8'hA5 -> same cycle x=0, x_valid=0, done=0, load_ready=1; no done pulse afterwards.
- bit_en tied 1, load 8'hB2 -> x sequence 1,0,1,1,0,0,1,0 on 8 consecutive cycles starting 1 cycle after accept; done pulses once; load_ready returns 1 after 1 gap cycle.
- bit_en=1 every 3rd cycle, load 8'h0F -> each bit held 3 cycles; x_valid continuous for 24 cycles; x stable between strobes.
- GAP_CYCLES=0, load_valid held high with 8'h81 then 8'h7E -> second word's first bit appears 1 cycle after first word's done; total 16 valid bits with a 1-cycle x_valid=0 bubble.
- load_valid pulsed during SEND with 8'hFF -> ignored; serial output is still only the original word.
- SEQ_BIT_TX_PARITY_EN defined:
  - Load 8'h07 -> 8 data bits then x=1 (3 ones), done after 9th bit.
  - Load 8'h03 -> parity bit 0.

Source files
------------

// File: rtl/seq_bit_tx.sv
// -----------------------------------------------------------------------------
// seq_bit_tx
//
// Serial stimulus transmitter. A WIDTH-bit pattern is accepted over a
// valid/ready handshake and shifted out MSB-first on `x`, one bit per cycle
// with bit_en=1. It feeds the `x` input of the serial sequence-detector FSMs.
// After each word, GAP_CYCLES enabled cycles of idle line are inserted before
// the next word can be accepted.
//
// Optional build macro: SEQ_BIT_TX_PARITY_EN
//   When defined, an even-parity trailer bit (XOR of the WIDTH captured bits)
//   follows the last data bit, so a word occupies WIDTH+1 bit periods.
//
// Parameters:
//   WIDTH       pattern length in bits (>= 2)
//   GAP_CYCLES  idle enabled-cycles after each word (0 allowed)
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   load_valid  source offers load_data
//   load_data   pattern to send, bit WIDTH-1 sent first
//   load_ready  transmitter can accept a word this cycle (combinational, IDLE)
//   bit_en      bit-rate strobe; the serial position advances only when high
//   x           serial data bit (registered)
//   x_valid     x carries a pattern/parity bit (registered)
//   done        one-cycle pulse when the last bit of a word has finished
// -----------------------------------------------------------------------------
module seq_bit_tx #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             bit_en,
  output logic             x,
  output logic             x_valid,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
`ifdef SEQ_BIT_TX_PARITY_EN
    ,
    S_PAR  = 2'd3
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [GW-1:0]    gap_q,   gap_d;
  logic             x_q,     x_d;
  logic             x_valid_q, x_valid_d;
  logic             done_q,  done_d;
  logic             word_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    x_d       = x_q;
    x_valid_d = x_valid_q;
    done_d    = 1'b0;
    word_end  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Acceptance ignores bit_en: the first bit is on the line one cycle
        // after the handshake, then waits for a strobe like every other bit.
        if (load_valid) begin
          shreg_d   = load_data;
          x_d       = load_data[WIDTH-1];
          x_valid_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_SEND;
        end
      end

      S_SEND: begin
        if (bit_en) begin
          if (cnt_q != CNT_LAST) begin
            // Rotate rather than zero-fill: after WIDTH-1 steps the register
            // still holds every captured bit, so its XOR is the word parity.
            shreg_d = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
            x_d     = shreg_q[WIDTH-2];
            cnt_d   = cnt_q + 1'b1;
          end else begin
`ifdef SEQ_BIT_TX_PARITY_EN
            x_d     = ^shreg_q;
            state_d = S_PAR;
`else
            word_end = 1'b1;
`endif
          end
        end
      end

`ifdef SEQ_BIT_TX_PARITY_EN
      S_PAR: begin
        if (bit_en) begin
          word_end = 1'b1;
        end
      end
`endif

      S_GAP: begin
        if (bit_en) begin
          if (gap_q == GAP_LAST) begin
            gap_d   = '0;
            state_d = S_IDLE;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Shared word-completion step: drop the line, pulse done, and skip the
    // gap entirely when none is configured.
    if (word_end) begin
      x_d       = 1'b0;
      x_valid_d = 1'b0;
      done_d    = 1'b1;
      gap_d     = '0;
      state_d   = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
    end
  end

  assign load_ready = (state_q == S_IDLE);
  assign x          = x_q;
  assign x_valid    = x_valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_seq_bit_tx.sv
// -----------------------------------------------------------------------------
// tb_seq_bit_tx
//
// Drives two transmitters side by side (GAP_CYCLES=1 and GAP_CYCLES=0) from
// per-instance word FIFOs and compares every output on every cycle against a
// reference model that treats a word as a list of bits to be emitted, one per
// strobe, followed by a counted idle gap. Honours SEQ_BIT_TX_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_seq_bit_tx;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_en = 1'b0;
  logic       lv [2];
  logic [W-1:0] ld [2];
  logic       lr [2];
  logic       xs [2];
  logic       xv [2];
  logic       dn [2];

  always #5 clk = ~clk;

  seq_bit_tx #(.WIDTH(W), .GAP_CYCLES(1)) u_gap1 (
    .clk(clk), .rst(rst), .load_valid(lv[0]), .load_data(ld[0]),
    .load_ready(lr[0]), .bit_en(bit_en), .x(xs[0]), .x_valid(xv[0]), .done(dn[0])
  );

  seq_bit_tx #(.WIDTH(W), .GAP_CYCLES(0)) u_gap0 (
    .clk(clk), .rst(rst), .load_valid(lv[1]), .load_data(ld[1]),
    .load_ready(lr[1]), .bit_en(bit_en), .x(xs[1]), .x_valid(xv[1]), .done(dn[1])
  );

  // Source FIFOs
  logic [W-1:0] src_data [2][0:63];
  int           src_head [2];
  int           src_tail [2];
  logic         glitch   [2];

  // Reference model state
  logic m_word  [2][0:15];
  int   m_len   [2];
  int   m_idx   [2];
  int   m_gap   [2];
  logic m_x     [2];
  logic m_xv    [2];
  logic m_done  [2];
  logic m_ready [2];

  int   mode;
  int   cyc;
  int   total_cnt;
  int   pass_cnt;

  function automatic int gap_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_len[i] = 0; m_idx[i] = 0; m_gap[i] = 0;
      m_x[i] = 1'b0; m_xv[i] = 1'b0; m_done[i] = 1'b0; m_ready[i] = 1'b1;
      src_head[i] = 0; src_tail[i] = 0; glitch[i] = 1'b0;
    end
  endtask

  task automatic push(input int i, input logic [W-1:0] d);
    src_data[i][src_tail[i]] = d;
    src_tail[i]++;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d.x", i),          xs[i], m_x[i]);
      check($sformatf("u%0d.x_valid", i),    xv[i], m_xv[i]);
      check($sformatf("u%0d.done", i),       dn[i], m_done[i]);
      check($sformatf("u%0d.load_ready", i), lr[i], m_ready[i]);
    end
  endtask

  task automatic drive();
    case (mode)
      0:       bit_en = 1'b1;
      1:       bit_en = (cyc % 3 == 0);
      default: bit_en = 1'($urandom_range(0, 1));
    endcase
    for (int i = 0; i < 2; i++) begin
      if (glitch[i]) begin
        lv[i] = 1'b1;
        ld[i] = 8'hFF;
      end else if (src_head[i] != src_tail[i]) begin
        lv[i] = 1'b1;
        ld[i] = src_data[i][src_head[i]];
      end else begin
        lv[i] = 1'b0;
        ld[i] = 8'h00;
      end
    end
  endtask

  // One clock edge of the reference: a word is a bit list emitted one element
  // per strobe, then GAP enabled cycles of silence.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      if (m_ready[i]) begin
        if (lv[i]) begin
          for (int k = 0; k < W; k++) m_word[i][k] = ld[i][W-1-k];
          m_len[i] = W;
`ifdef SEQ_BIT_TX_PARITY_EN
          m_word[i][W] = 1'($countones(ld[i]) % 2);
          m_len[i] = W + 1;
`endif
          m_x[i] = m_word[i][0];
          m_idx[i] = 1;
          m_xv[i] = 1'b1;
          m_ready[i] = 1'b0;
          if (!glitch[i]) src_head[i]++;
        end
      end else if (m_xv[i]) begin
        if (bit_en) begin
          if (m_idx[i] < m_len[i]) begin
            m_x[i] = m_word[i][m_idx[i]];
            m_idx[i]++;
          end else begin
            m_x[i] = 1'b0;
            m_xv[i] = 1'b0;
            m_done[i] = 1'b1;
            m_gap[i] = gap_of(i);
            m_ready[i] = (gap_of(i) == 0);
          end
        end
      end else if (bit_en) begin
        m_gap[i]--;
        if (m_gap[i] == 0) m_ready[i] = 1'b1;
      end
    end
  endtask

  task automatic step();
    drive();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
    for (int i = 0; i < 2; i++) glitch[i] = 1'b0;
    cyc++;
  endtask

  function automatic bit all_idle();
    return (src_head[0] == src_tail[0]) && (src_head[1] == src_tail[1]) &&
           m_ready[0] && m_ready[1];
  endfunction

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while (!all_idle() && n < budget) begin
      step();
      n++;
    end
    if (!all_idle()) begin
      total_cnt++;
      $error("FAIL drain_timeout cycle=%0d observed=busy expected=idle", cyc);
    end
    step();
    step();
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    cyc       = 0;
    mode      = 0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      lv[i] = 1'b0;
      ld[i] = '0;
    end

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;

    // Strobe every cycle, 8'hB2
    mode = 0;
    push(0, 8'hB2); push(1, 8'hB2);
    run_idle(100);

    // Strobe every third cycle, 8'h0F
    mode = 1;
    push(0, 8'h0F); push(1, 8'h0F);
    run_idle(200);

    // Back-to-back words with load_valid held
    mode = 0;
    push(0, 8'h81); push(1, 8'h81);
    push(0, 8'h7E); push(1, 8'h7E);
    run_idle(100);

    // Spurious load during SEND must be ignored
    push(0, 8'h3C); push(1, 8'h3C);
    repeat (3) step();
    for (int i = 0; i < 2; i++) glitch[i] = !m_ready[i];
    step();
    run_idle(100);

    // Parity-relevant patterns
    push(0, 8'h07); push(1, 8'h07);
    push(0, 8'h03); push(1, 8'h03);
    run_idle(100);

    // Random words, random strobe, random arrival spacing
    mode = 2;
    for (int n = 0; n < 20; n++) begin
      push(0, 8'($urandom));
      push(1, 8'($urandom));
      repeat ($urandom_range(0, 12)) step();
    end
    run_idle(3000);

    // Asynchronous reset in the middle of a word
    mode = 0;
    push(0, 8'hA5); push(1, 8'hA5);
    repeat (4) step();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    check_all();
    rst = 1'b0;
    repeat (12) step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
